invsubbytes_seq: RTL and testbench



---
 rtl/aes_dec_pkg.sv | 29 ++
 rtl/inv_sbox.sv | 11 +
 rtl/invsubbytes_seq.sv | 108 ++++++++++
 tb/tb_invsubbytes_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decryption definitions: state/byte widths, FSM state encoding
// and the FIPS-197 inverse S-box table.
package aes_dec_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_BYTE_W  = 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [AES_BYTE_W-1:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sbox.sv
// Single inverse S-box lane: combinational lookup in the shared table.
module inv_sbox
   import aes_dec_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] data_i,
   output logic [AES_BYTE_W-1:0] data_o
);

   assign data_o = INV_SBOX[data_i];

endmodule

// File: rtl/invsubbytes_seq.sv
// Iterative inverse SubBytes: BYTES_PER_CYCLE S-box lanes walk the state over STEPS cycles.
// Optional `INVSUBBYTES_BYPASS_EN adds a bypass input that skips substitution.
module invsubbytes_seq
   import aes_dec_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] state_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] state_out,
   output logic                   busy
`ifdef INVSUBBYTES_BYPASS_EN
   ,
   input  logic                   bypass
`endif
);

   localparam int STEPS = 16 / BYTES_PER_CYCLE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   // Byte 0 sits in the top bits, so group k lives at index STEPS-1-k and lane l at BPC-1-l.
   logic [STEPS-1:0][BYTES_PER_CYCLE-1:0][AES_BYTE_W-1:0] work_q, work_d;
   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]        grp;
   logic [AES_BYTE_W-1:0]   lane_in  [BYTES_PER_CYCLE];
   logic [AES_BYTE_W-1:0]   lane_out [BYTES_PER_CYCLE];
   logic                    skip;

`ifdef INVSUBBYTES_BYPASS_EN
   assign skip = bypass;
`else
   assign skip = 1'b0;
`endif

   assign grp = CNT_W'(STEPS - 1) - cnt_q;

   always_comb begin
      for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
         lane_in[l] = work_q[grp][BYTES_PER_CYCLE-1-l];
      end
   end

   for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
      inv_sbox u_inv_sbox (
         .data_i (lane_in[g]),
         .data_o (lane_out[g])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = state_in;
               cnt_d   = '0;
               state_d = skip ? DONE : RUN;
            end
         end
         RUN: begin
            for (int unsigned l = 0; l < BYTES_PER_CYCLE; l++) begin
               work_d[grp][BYTES_PER_CYCLE-1-l] = lane_out[l];
            end
            if (cnt_q == CNT_W'(STEPS - 1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign state_out = work_q;

endmodule

// File: tb/tb_invsubbytes_seq.sv
// Scoreboard bench for invsubbytes_seq: three instances (BPC 4, 1, 16) with
// directed FIPS-197 vectors; a negedge monitor pops expected results on out_valid.
module tb_invsubbytes_seq;

   localparam logic [127:0] C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
   localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

   typedef struct {
      logic [127:0] data;
      int unsigned  cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         iv  [3];
   logic         ir  [3];
   logic         ov  [3];
   logic         orr [3];
   logic         bsy [3];
   logic         byp [3];
   logic [127:0] si  [3];
   logic [127:0] so  [3];

   int unsigned  cyc = 0;
   int           checks = 0;
   int           fails = 0;
   exp_t         sb [3][$];
   logic         pov [3];
   logic [127:0] cur [3];
   int unsigned  rise_log [$];
   exp_t         e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int BPC = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
      invsubbytes_seq #(.BYTES_PER_CYCLE(BPC)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .state_in  (si[g]),
         .out_valid (ov[g]),
         .out_ready (orr[g]),
         .state_out (so[g]),
         .busy      (bsy[g])
`ifdef INVSUBBYTES_BYPASS_EN
         ,
         .bypass    (byp[g])
`endif
      );
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accepting edge.
   task automatic send(input int d, input logic [127:0] data, input logic [127:0] exp,
                       input bit push, input int unsigned lat);
      int n = 0;
      si[d] = data;
      iv[d] = 1'b1;
      while (!ir[d] && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("accept_dut%0d", d), {127'b0, ir[d]}, 128'd1);
      if (push) sb[d].push_back('{data: exp, cyc: cyc + 1 + lat});
      @(negedge clk);
      iv[d] = 1'b0;
      si[d] = ~data;
   endtask

   task automatic wait_idle(input int d);
      int n = 0;
      while (!ir[d] && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("idle_dut%0d", d), {127'b0, ir[d]}, 128'd1);
   endtask

   task automatic wait_drain(input int d);
      int n = 0;
      while (sb[d].size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("drain_dut%0d_pending", d), 128'(sb[d].size()), 128'd0);
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (ov[d] && !pov[d]) begin
            if (sb[d].size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_out_dut%0d: got %h expected no output", d, so[d]);
               cur[d] = so[d];
            end else begin
               e = sb[d].pop_front();
               chk($sformatf("data_dut%0d", d), so[d], e.data);
               chk($sformatf("latency_dut%0d", d), 128'(cyc), 128'(e.cyc));
               cur[d] = e.data;
               if (d == 0) rise_log.push_back(cyc);
            end
         end else if (ov[d]) begin
            chk($sformatf("hold_dut%0d", d), so[d], cur[d]);
         end
         pov[d] = ov[d];
      end
   end

   initial begin
      int base;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; orr[d] = 1'b1; byp[d] = 1'b0; si[d] = '0;
         pov[d] = 1'b0; cur[d] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_in_ready_dut%0d", d), {127'b0, ir[d]}, 128'd1);
         chk($sformatf("rst_out_valid_dut%0d", d), {127'b0, ov[d]}, 128'd0);
         chk($sformatf("rst_busy_dut%0d", d), {127'b0, bsy[d]}, 128'd0);
         chk($sformatf("rst_state_out_dut%0d", d), so[d], 128'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      send(0, '0, {16{8'h52}}, 1'b1, 4);
      send(0, C1_IN, C1_OUT, 1'b1, 4);
      wait_idle(0);

      // backpressure: result must hold and a stray in_valid must be ignored
      orr[0] = 1'b0;
      send(0, {16{8'h63}}, '0, 1'b1, 4);
      while (!ov[0]) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("bp_state_out", so[0], 128'd0);
         chk("bp_in_ready", {127'b0, ir[0]}, 128'd0);
         chk("bp_out_valid", {127'b0, ov[0]}, 128'd1);
         if (i == 3) begin
            si[0] = {16{8'h55}};
            iv[0] = 1'b1;
         end
         if (i == 4) iv[0] = 1'b0;
         @(negedge clk);
      end
      orr[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", {127'b0, ir[0]}, 128'd1);
      chk("bp_release_out_valid", {127'b0, ov[0]}, 128'd0);

      base = rise_log.size();
      send(0, '0, {16{8'h52}}, 1'b1, 4);
      send(0, '1, {16{8'h7d}}, 1'b1, 4);
      wait_drain(0);
      chk("b2b_spacing", 128'(rise_log[base+1] - rise_log[base]), 128'd6);
      wait_idle(0);

      // reset during the second RUN cycle discards the block
      send(0, {16{8'h11}}, '0, 1'b0, 4);
      @(negedge clk);
      chk("mid_run_busy", {127'b0, bsy[0]}, 128'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_run_out_valid", {127'b0, ov[0]}, 128'd0);
      chk("rst_run_state_out", so[0], 128'd0);
      chk("rst_run_busy", {127'b0, bsy[0]}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", {127'b0, ir[0]}, 128'd1);
      send(0, {16{8'h01}}, {16{8'h09}}, 1'b1, 4);
      wait_drain(0);

      send(1, C1_IN, C1_OUT, 1'b1, 16);
      wait_drain(1);
      send(2, C1_IN, C1_OUT, 1'b1, 1);
      wait_drain(2);

`ifdef INVSUBBYTES_BYPASS_EN
      wait_idle(0);
      byp[0] = 1'b1;
      send(0, C1_IN, C1_IN, 1'b1, 0);
      byp[0] = 1'b0;
      wait_drain(0);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
